// File: rtl/floating_point_unit_if.sv
// Control/data bundle for floating_point_unit.
// master: external control unit (drives operands and steering, reads result).
// slave : the datapath (reads operands and steering, drives result/status).
interface floating_point_unit_if;
  logic [31:0]        floatingPoint1;
  logic [31:0]        floatingPoint2;
  logic               controlToMux01;
  logic               controlToMux02;
  logic               controlToMux03;
  logic               controlToMux04;
  logic               controlToMux05;
  logic               controlToMux06;
  logic [7:0]         controlShiftRight;
  logic signed [22:0] controlShiftLeftOrRight;
  logic [3:0]         controlToIncreaseOrDecrease;
  logic               IncreaseOrDecreaseEnable;
  logic               muxAControl;
  logic               muxBControl;
  logic               muxControl;
  logic               sumOrMultiplication;
  logic               loadRegA;
  logic               loadRegB;
  logic [3:0]         bigALUOperation;
  logic [3:0]         smallALUOperation;
  logic               muxAControlSmall;
  logic               muxBControlSmall;
  logic               loadRegSmall;
  logic [31:0]        resultadoFinal;
  logic               finalizeOperation;

  modport master (
    output floatingPoint1, floatingPoint2,
    output controlToMux01, controlToMux02, controlToMux03,
    output controlToMux04, controlToMux05, controlToMux06,
    output controlShiftRight, controlShiftLeftOrRight,
    output controlToIncreaseOrDecrease, IncreaseOrDecreaseEnable,
    output muxAControl, muxBControl, muxControl, sumOrMultiplication,
    output loadRegA, loadRegB, bigALUOperation, smallALUOperation,
    output muxAControlSmall, muxBControlSmall, loadRegSmall,
    input  resultadoFinal, finalizeOperation
  );

  modport slave (
    input  floatingPoint1, floatingPoint2,
    input  controlToMux01, controlToMux02, controlToMux03,
    input  controlToMux04, controlToMux05, controlToMux06,
    input  controlShiftRight, controlShiftLeftOrRight,
    input  controlToIncreaseOrDecrease, IncreaseOrDecreaseEnable,
    input  muxAControl, muxBControl, muxControl, sumOrMultiplication,
    input  loadRegA, loadRegB, bigALUOperation, smallALUOperation,
    input  muxAControlSmall, muxBControlSmall, loadRegSmall,
    output resultadoFinal, finalizeOperation
  );
endinterface

// File: rtl/floating_point_unit.sv
// Externally sequenced binary32 add/multiply datapath.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - floating_point_unit_if.slave: operands, steering controls, result
// Internal 48-bit significand format: binary point at bit 46, bit 47 is
// carry headroom, bits [22:0] are guard/sticky extension.
module floating_point_unit (
  input  logic                 clk,
  input  logic                 reset,
  floating_point_unit_if.slave bus
);

  logic [47:0]       r_regA, r_regB;
  logic              r_signA, r_signB;
  logic signed [9:0] r_regSmall;
  logic [31:0]       r_result;
  logic              r_finalize;

  logic [7:0]  w_expA, w_expB;
  logic [23:0] w_sigA, w_sigB, w_resSig;

  assign w_expA   = bus.floatingPoint1[30:23];
  assign w_expB   = bus.floatingPoint2[30:23];
  assign w_sigA   = (w_expA == 8'd0) ? 24'd0 : {1'b1, bus.floatingPoint1[22:0]};
  assign w_sigB   = (w_expB == 8'd0) ? 24'd0 : {1'b1, bus.floatingPoint2[22:0]};
  assign w_resSig = (r_result[30:23] == 8'd0) ? 24'd0 : {1'b1, r_result[22:0]};

  // Operand steering into the aligner and big-ALU registers
  logic [23:0] w_srcA, w_srcB, w_shIn, w_other;
  logic        w_srcASign, w_srcBSign, w_shSign, w_otherSign;
  logic [47:0] w_shWide, w_shifted, w_regASrc, w_regBSrc;
  logic        w_regASign, w_regBSign;

  always_comb begin
    w_srcA     = bus.controlToMux04 ? w_sigA : w_resSig;
    w_srcB     = bus.controlToMux04 ? w_sigB : w_resSig;
    w_srcASign = bus.controlToMux04 ? bus.floatingPoint1[31] : r_result[31];
    w_srcBSign = bus.controlToMux04 ? bus.floatingPoint2[31] : r_result[31];
    if (bus.controlToMux01) begin
      w_shIn = w_srcA; w_shSign = w_srcASign; w_other = w_srcB; w_otherSign = w_srcBSign;
    end else begin
      w_shIn = w_srcB; w_shSign = w_srcBSign; w_other = w_srcA; w_otherSign = w_srcASign;
    end
  end

  assign w_shWide = {1'b0, w_shIn, 23'd0};

  // Alignment shifter: bits pushed out are folded into bit 0 as sticky
  always_comb begin
    if (bus.controlShiftRight >= 8'd26) begin
      w_shifted = {47'd0, |w_shIn};
    end else begin
      w_shifted    = w_shWide >> bus.controlShiftRight;
      w_shifted[0] = w_shifted[0] | (|(w_shWide & ~({48{1'b1}} << bus.controlShiftRight)));
    end
  end

  assign w_regASrc  = bus.muxAControl ? w_shifted : {1'b0, w_srcA, 23'd0};
  assign w_regASign = bus.muxAControl ? w_shSign : w_srcASign;
  assign w_regBSrc  = bus.muxBControl ? {1'b0, w_srcB, 23'd0} : {1'b0, w_other, 23'd0};
  assign w_regBSign = bus.muxBControl ? w_srcBSign : w_otherSign;

  // Small ALU (exponents)
  logic signed [9:0] w_smallA, w_smallB, w_smallRes;

  assign w_smallA = {2'b00, (bus.muxAControlSmall ? w_expA : w_expA)};
  assign w_smallB = bus.muxBControlSmall ? ($signed({2'b00, w_expB}) - 10'sd127)
                                         : $signed({2'b00, w_expB});

  always_comb begin
    case (bus.smallALUOperation)
      4'b0000: w_smallRes = w_smallA + w_smallB;
      4'b0011: w_smallRes = w_smallA - w_smallB;
      4'b0001: w_smallRes = w_smallA;
      4'b0010: w_smallRes = w_smallB;
      default: w_smallRes = '0;
    endcase
  end

  // Big ALU (significands)
  logic [47:0] w_bigRes;
  logic        w_bigSign, w_aGeB;

  assign w_aGeB = (r_regA >= r_regB);

  always_comb begin
    w_bigRes  = '0;
    w_bigSign = 1'b0;
    if (bus.sumOrMultiplication) begin
      case (bus.bigALUOperation)
        4'b0000: begin
          if (r_signA == r_signB) begin
            w_bigRes = r_regA + r_regB; w_bigSign = r_signA;
          end else if (w_aGeB) begin
            w_bigRes = r_regA - r_regB; w_bigSign = r_signA;
          end else begin
            w_bigRes = r_regB - r_regA; w_bigSign = r_signB;
          end
        end
        4'b0001: begin
          w_bigRes = r_regA + r_regB; w_bigSign = r_signA;
        end
        4'b0010: begin
          if (w_aGeB) begin
            w_bigRes = r_regA - r_regB; w_bigSign = r_signA;
          end else begin
            w_bigRes = r_regB - r_regA; w_bigSign = ~r_signA;
          end
        end
        default: ;
      endcase
    end else begin
      w_bigRes  = 48'(r_regA[46:23]) * 48'(r_regB[46:23]);
      w_bigSign = bus.floatingPoint1[31] ^ bus.floatingPoint2[31];
    end
  end

  // Normalizer source selection
  logic [47:0]        w_nIn;
  logic signed [31:0] w_nExp;
  logic               w_nSign, w_sign;

  always_comb begin
    if (bus.controlToMux03) begin
      w_nIn   = {1'b0, w_resSig, 23'd0};
      w_nExp  = $signed({24'd0, r_result[30:23]});
      w_nSign = r_result[31];
    end else begin
      w_nIn   = w_bigRes;
      w_nSign = w_bigSign;
      if (bus.sumOrMultiplication)
        w_nExp = $signed({24'd0, (bus.controlToMux02 ? w_expA : w_expB)});
      else
        w_nExp = {{22{r_regSmall[9]}}, r_regSmall};
    end
  end

  assign w_sign = bus.controlToMux05 ? bus.floatingPoint1[31] : w_nSign;

  // Leading-one detect
  logic [5:0] w_lead;
  logic       w_hasOne;

  always_comb begin
    w_lead   = '0;
    w_hasOne = |w_nIn;
    for (int unsigned i = 0; i < 48; i++)
      if (w_nIn[i]) w_lead = 6'(i);
  end

  // Normalize, adjust, round-to-nearest-even, pack
  logic signed [31:0] w_shAmt, w_expN, w_expR;
  logic [31:0]        w_shMag;
  logic [47:0]        w_normV;
  logic               w_lost, w_sticky, w_roundUp;
  logic [24:0]        w_sigR;
  logic [22:0]        w_frac;
  logic [31:0]        w_packed;

  always_comb begin
    w_shAmt = '0;
    w_shMag = '0;
    w_normV = '0;
    w_lost  = 1'b0;
    // positive amount = shift right, negative = shift left
    if (bus.controlShiftLeftOrRight != '0)
      w_shAmt = {{9{bus.controlShiftLeftOrRight[22]}}, bus.controlShiftLeftOrRight};
    else if (w_hasOne)
      w_shAmt = $signed({26'd0, w_lead}) - 32'sd46;
    if (!w_shAmt[31]) begin
      w_shMag = w_shAmt;
      w_normV = w_nIn >> w_shMag;
      w_lost  = |(w_nIn & ~({48{1'b1}} << w_shMag));
    end else begin
      w_shMag = -w_shAmt;
      w_normV = w_nIn << w_shMag;
    end
    w_expN = w_nExp + w_shAmt;
    if (bus.IncreaseOrDecreaseEnable) begin
      if (bus.controlToIncreaseOrDecrease[3])
        w_expN = w_expN - $signed({29'd0, bus.controlToIncreaseOrDecrease[2:0]});
      else
        w_expN = w_expN + $signed({29'd0, bus.controlToIncreaseOrDecrease[2:0]});
    end
    w_sticky  = (|w_normV[21:0]) | w_lost;
    w_roundUp = w_normV[22] & (w_sticky | w_normV[23]);
    w_sigR    = {1'b0, w_normV[46:23]} + {24'd0, w_roundUp};
    w_expR    = w_sigR[24] ? (w_expN + 32'sd1) : w_expN;
    w_frac    = w_sigR[24] ? w_sigR[23:1] : w_sigR[22:0];
    // a set bit 47 can only survive a manual override and exceeds the format
    if (w_nIn == '0)
      w_packed = '0;
    else if ((w_expR >= 255) || w_normV[47])
      w_packed = {w_sign, 8'hFF, 23'd0};
    else if ((w_expR <= 0) || !(w_sigR[24] | w_sigR[23]))
      w_packed = {w_sign, 31'd0};
    else
      w_packed = {w_sign, w_expR[7:0], w_frac};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_regA     <= '0;
      r_regB     <= '0;
      r_signA    <= 1'b0;
      r_signB    <= 1'b0;
      r_regSmall <= '0;
      r_result   <= '0;
      r_finalize <= 1'b0;
    end else begin
      if (bus.loadRegSmall) r_regSmall <= w_smallRes;
      if (bus.loadRegA) begin
        r_regA  <= w_regASrc;
        r_signA <= w_regASign;
      end
      if (bus.loadRegB) begin
        r_regB  <= w_regBSrc;
        r_signB <= w_regBSign;
      end
      if (bus.muxControl) r_result <= w_packed;
      r_finalize <= bus.muxControl;
    end
  end

  assign bus.resultadoFinal    = bus.controlToMux06 ? bus.floatingPoint1 : r_result;
  assign bus.finalizeOperation = r_finalize;

endmodule

// File: tb/tb_floating_point_unit.sv
// Self-checking bench for floating_point_unit: directed cases plus random
// add/multiply checked against a real-arithmetic binary32 reference.
module tb_floating_point_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  floating_point_unit_if bus();

  floating_point_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference model: exact real value of an operand (exp 0 is zero)
  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real to_real(input logic [31:0] f);
    int  e = int'(f[30:23]);
    real v;
    if (e == 0) return 0.0;
    v = real'(int'({1'b1, f[22:0]})) * pow2(e - 150);
    return f[31] ? -v : v;
  endfunction

  // Round an exact real to binary32, ties-to-even, flush small to signed zero
  function automatic logic [31:0] round_f32(input real x);
    logic s;
    real  m, sc, fr;
    int   e, ip, b;
    if (x == 0.0) return 32'h0;
    s = (x < 0.0);
    m = s ? -x : x;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    sc = m * 8388608.0;
    ip = $rtoi(sc);
    fr = sc - real'(ip);
    if ((fr > 0.5) || ((fr == 0.5) && ip[0])) ip++;
    if (ip == 16777216) begin ip = 8388608; e++; end
    b = e + 127;
    if (b >= 255) return {s, 8'hFF, 23'd0};
    if (b <= 0)   return {s, 31'd0};
    return {s, b[7:0], ip[22:0]};
  endfunction

  task automatic set_defaults();
    bus.controlToMux01 = 1'b0; bus.controlToMux02 = 1'b0; bus.controlToMux03 = 1'b0;
    bus.controlToMux04 = 1'b1; bus.controlToMux05 = 1'b0; bus.controlToMux06 = 1'b0;
    bus.controlShiftRight = '0; bus.controlShiftLeftOrRight = '0;
    bus.controlToIncreaseOrDecrease = '0; bus.IncreaseOrDecreaseEnable = 1'b0;
    bus.muxAControl = 1'b0; bus.muxBControl = 1'b0; bus.muxControl = 1'b1;
    bus.sumOrMultiplication = 1'b1; bus.loadRegA = 1'b1; bus.loadRegB = 1'b1;
    bus.bigALUOperation = 4'b0000; bus.smallALUOperation = 4'b0000;
    bus.muxAControlSmall = 1'b0; bus.muxBControlSmall = 1'b0; bus.loadRegSmall = 1'b1;
  endtask

  // Acts as the control unit for an add: align the smaller-exponent operand
  task automatic do_add(input logic [31:0] a, input logic [31:0] b, input string tag);
    int ea, eb;
    @(negedge clk);
    set_defaults();
    bus.floatingPoint1 = a;
    bus.floatingPoint2 = b;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea >= eb) begin
      bus.controlToMux01 = 1'b0; bus.controlShiftRight = 8'(ea - eb); bus.controlToMux02 = 1'b1;
    end else begin
      bus.controlToMux01 = 1'b1; bus.controlShiftRight = 8'(eb - ea); bus.controlToMux02 = 1'b0;
    end
    bus.muxAControl = 1'b1;
    bus.muxBControl = 1'b0;
    bus.smallALUOperation = 4'b0011;
    @(posedge clk); @(posedge clk); #1;
    check_val(tag, bus.resultadoFinal, round_f32(to_real(a) + to_real(b)));
    check_val({tag, "_fin"}, {31'd0, bus.finalizeOperation}, 32'd1);
  endtask

  // Multiply: result write held off on the first edge
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input string tag);
    @(negedge clk);
    set_defaults();
    bus.floatingPoint1 = a;
    bus.floatingPoint2 = b;
    bus.sumOrMultiplication = 1'b0;
    bus.muxAControl = 1'b0;
    bus.muxBControl = 1'b1;
    bus.muxAControlSmall = 1'b1;
    bus.muxBControlSmall = 1'b1;
    bus.smallALUOperation = 4'b0000;
    bus.muxControl = 1'b0;
    @(posedge clk); #1;
    check_val({tag, "_fin0"}, {31'd0, bus.finalizeOperation}, 32'd0);
    @(negedge clk);
    bus.muxControl = 1'b1;
    @(posedge clk); #1;
    check_val(tag, bus.resultadoFinal, round_f32(to_real(a) * to_real(b)));
    check_val({tag, "_fin"}, {31'd0, bus.finalizeOperation}, 32'd1);
  endtask

  initial begin
    logic [31:0] a, b;
    int ea, eb;
    set_defaults();
    bus.floatingPoint1 = '0;
    bus.floatingPoint2 = '0;
    bus.muxControl = 1'b0;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check_val("reset_res", bus.resultadoFinal, 32'h0);
    check_val("reset_fin", {31'd0, bus.finalizeOperation}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases with hand-derived results
    do_add(32'h3F400000, 32'h40100000, "add_0.75_2.25");
    check_val("add_0.75_2.25_const", bus.resultadoFinal, 32'h40400000);
    do_mul(32'h3FC00000, 32'h40000000, "mul_1.5_2");
    check_val("mul_1.5_2_const", bus.resultadoFinal, 32'h40400000);
    do_add(32'h40400000, 32'hBF800000, "add_3_m1");
    check_val("add_3_m1_const", bus.resultadoFinal, 32'h40000000);
    do_add(32'h3F800000, 32'h33800000, "round_tie_even");
    check_val("round_tie_even_const", bus.resultadoFinal, 32'h3F800000);
    do_add(32'h3F800000, 32'hBF800000, "add_cancel_zero");
    check_val("add_cancel_zero_const", bus.resultadoFinal, 32'h00000000);
    do_mul(32'h7F000000, 32'h40000000, "mul_overflow");
    check_val("mul_overflow_const", bus.resultadoFinal, 32'h7F800000);
    do_mul(32'h00000000, 32'h40000000, "mul_zero");
    check_val("mul_zero_const", bus.resultadoFinal, 32'h00000000);

    // Bypass of operand A to the output
    @(negedge clk);
    bus.floatingPoint1 = 32'hC1234567;
    bus.controlToMux06 = 1'b1;
    #1;
    check_val("bypass", bus.resultadoFinal, 32'hC1234567);

    // Reset between the load edge and the result edge
    do_add(32'h3F400000, 32'h40100000, "pre_reset_add");
    @(negedge clk);
    bus.floatingPoint2 = 32'h41000000;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("midop_reset_res", bus.resultadoFinal, 32'h0);
    check_val("midop_reset_fin", {31'd0, bus.finalizeOperation}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Random adds with exponent spread small enough for exact real sums
    for (int n = 0; n < 30; n++) begin
      ea = $urandom_range(150, 100);
      eb = ea - 20 + $urandom_range(40, 0);
      a = {1'($urandom), 8'(ea), 23'($urandom)};
      b = {1'($urandom), 8'(eb), 23'($urandom)};
      do_add(a, b, $sformatf("rnd_add_%0d", n));
    end

    // Random multiplies, wide enough exponent range to reach overflow/underflow
    for (int n = 0; n < 30; n++) begin
      ea = $urandom_range(215, 40);
      eb = $urandom_range(215, 40);
      a = {1'($urandom), 8'(ea), 23'($urandom)};
      b = {1'($urandom), 8'(eb), 23'($urandom)};
      do_mul(a, b, $sformatf("rnd_mul_%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
